pipeline_fifo: RTL and testbench
================================

PIPELINE_FIFO -- requirements
Module: pipeline_fifo

Interface
REQ-001 Width, default 8, data bits per token.
REQ-002 Depth, default 4, token slots; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 d  input  Width  incoming token data.
REQ-006 d_valid  input  1  upstream presents a token on d.
REQ-007 d_bp  output  1  backpressure to upstream; token not accepted while high.
REQ-008 q  output  Width  head-of-queue token data.
REQ-009 q_valid  output  1  q holds a valid token.
REQ-010 q_bp  input  1  downstream backpressure; head token not consumed while high.
REQ-011 count  output  $clog2(Depth)+1  number of tokens currently stored.

Function
REQ-012 Token accepted in a cycle SHALL mean d_valid && !d_bp at the rising edge; d SHALL be written to the slot at the write pointer.
REQ-013 Token consumed in a cycle SHALL mean q_valid && !q_bp at the rising edge; the read pointer SHALL advance.
REQ-014 d_bp SHALL equal (count == Depth) and SHALL depend on registered state only, with no combinational path from q_bp or d_valid.
REQ-015 q_valid SHALL equal (count != 0) and q SHALL equal the slot at the read pointer; no combinational path from d or d_valid to q or q_valid.
REQ-016 Latency: a token accepted into an empty FIFO at edge N SHALL appear with q_valid high after edge N; there is no same-cycle bypass.
REQ-017 count SHALL change as follows: +1 on accept only, -1 on consume only, unchanged on both or neither.
REQ-018 Accept and consume in the same cycle SHALL be legal at any occupancy from 1 to Depth-1 and SHALL sustain one token per cycle.
REQ-019 When full, d_bp SHALL stay high for the whole cycle even if a consume occurs that cycle; the freed slot is usable from the next cycle.
REQ-020 When empty, d_valid high with q_bp high SHALL still accept the token.
REQ-021 Both pointers SHALL wrap modulo Depth; ordering SHALL be strict FIFO across wrap.
REQ-022 While q_valid && q_bp, q SHALL hold stable.
REQ-023 While q_valid is low, q is don't-care.
REQ-024 d and d_valid SHALL be ignored whenever d_bp is high: no write and no pointer change.

Reset
REQ-025 While resetn is low at a rising edge, count and both pointers SHALL be set to 0; q_valid SHALL be 0 and d_bp SHALL be 0 after that edge.
REQ-026 Reset mid-operation SHALL discard all stored tokens, and any accept or consume in that cycle SHALL be ignored.
REQ-027 Storage contents SHALL NOT be reset.

Structure
REQ-028 Shared package llpm_pipeline_pkg SHALL hold the pointer/count width helper, used as clog2-based localparams, for reuse by other pipeline blocks.
REQ-029 Storage SHALL be a sub-module pipeline_fifo_mem with the following properties:
- one synchronous write port and one asynchronous read port;
- no reset.
REQ-030 Pointer and count control SHALL live in pipeline_fifo.

Verification
REQ-031 Fill: Depth=4, q_bp=1, push 0x11,0x22,0x33,0x44 on consecutive cycles -> count steps 1..4; d_bp=1 after the 4th edge; a 5th token 0x55 is not accepted.
REQ-032 Drain: from the full state of REQ-031, q_bp=0, d_valid=0 -> q shows 0x11,0x22,0x33,0x44 on successive cycles; then q_valid=0, count=0.
REQ-033 Streaming: q_bp=0, push 0x00..0x0F every cycle -> output in order at 1 token/cycle, one cycle behind input, with count stable at 1.
REQ-034 Full plus simultaneous pop: full with head 0x11, d_valid=1 d=0x99, q_bp=0 -> 0x11 consumed and 0x99 not accepted that cycle; count=3; 0x99 accepted the next cycle with count=4.
REQ-035 Wrap: push/pop 10 tokens 0xA0..0xA9 with random q_bp, seed fixed -> order preserved across two pointer wraps, and count matches a reference model every cycle.
REQ-036 Reset mid-operation: count=3, then resetn=0 for one cycle with d_valid=1 -> count=0, q_valid=0, d_bp=0; the next push 0x5A appears first at q.

Source files
------------

// File: rtl/llpm_pipeline_pkg.sv
// Shared sizing helpers for the llpm pipeline blocks.
// Pointer and occupancy-counter widths derive from the slot count.
package llpm_pipeline_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Pointer width; never below 1 so a 1-bit address is still legal.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

   // Counter must represent 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pipeline_fifo_mem.sv
// Token storage for pipeline_fifo: one synchronous write port and one
// asynchronous read port, contents deliberately not reset.
module pipeline_fifo_mem
   import llpm_pipeline_pkg::*;
#(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   parameter int unsigned AddrW = ptr_w(Depth)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AddrW-1:0] waddr,
   input  logic [Width-1:0] wdata,
   input  logic [AddrW-1:0] raddr,
   output logic [Width-1:0] rdata
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipeline_fifo.sv
// Valid/backpressure FIFO with registered-only handshake outputs.
// Pointers wrap naturally because Depth is a power of two.
module pipeline_fifo
   import llpm_pipeline_pkg::*;
#(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [Width-1:0]          d,
   input  logic                      d_valid,
   output logic                      d_bp,
   output logic [Width-1:0]          q,
   output logic                      q_valid,
   input  logic                      q_bp,
   output logic [cnt_w(Depth)-1:0]   count
);

   localparam int unsigned PtrW = ptr_w(Depth);
   localparam int unsigned CntW = cnt_w(Depth);
   localparam logic [CntW-1:0] Full = CntW'(Depth);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            accept;
   logic            consume;

   assign d_bp    = (count_q == Full);
   assign q_valid = (count_q != '0);
   assign count   = count_q;

   // Reset masks both handshakes so nothing is written or advanced that cycle.
   always_comb begin
      accept   = resetn && d_valid && !d_bp;
      consume  = resetn && q_valid && !q_bp;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept)  wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (consume) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({accept, consume})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (!resetn) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
   end

   pipeline_fifo_mem #(
      .Width (Width),
      .Depth (Depth),
      .AddrW (PtrW)
   ) u_mem (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr_q),
      .wdata (d),
      .raddr (rd_ptr_q),
      .rdata (q)
   );

endmodule

// File: tb/tb_pipeline_fifo.sv
// Self-checking bench for pipeline_fifo (Width=8, Depth=4) using a
// queue-based scoreboard of accepted tokens.
module tb_pipeline_fifo;

   localparam int unsigned Width = 8;
   localparam int unsigned Depth = 4;

   logic             clk;
   logic             resetn;
   logic [Width-1:0] d;
   logic             d_valid;
   logic             d_bp;
   logic [Width-1:0] q;
   logic             q_valid;
   logic             q_bp;
   logic [2:0]       count;

   int checks;
   int failures;
   logic [7:0] model[$];

   pipeline_fifo #(
      .Width (Width),
      .Depth (Depth)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .d       (d),
      .d_valid (d_valid),
      .d_bp    (d_bp),
      .q       (q),
      .q_valid (q_valid),
      .q_bp    (q_bp),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Compares outputs to the scoreboard, then clocks one edge with the given inputs.
   task automatic step(input logic dv, input logic [7:0] dd, input logic qb,
                       output logic acc, output logic cons);
      d_valid = dv;
      d       = dd;
      q_bp    = qb;
      #1;
      check("count", 32'(count), 32'(model.size()));
      check("d_bp", 32'(d_bp), 32'(model.size() == Depth));
      check("q_valid", 32'(q_valid), 32'(model.size() != 0));
      if (model.size() != 0) check("q", 32'(q), 32'(model[0]));
      acc  = dv && (model.size() < Depth);
      cons = (model.size() != 0) && !qb;
      @(posedge clk);
      if (cons) void'(model.pop_front());
      if (acc) model.push_back(dd);
      #1;
   endtask

   task automatic apply_reset(input logic dv, input logic [7:0] dd);
      resetn  = 1'b0;
      d_valid = dv;
      d       = dd;
      q_bp    = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      model.delete();
      d_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc, cons;
      logic [7:0] q_seen;
      int pushed, popped, cyc;

      checks   = 0;
      failures = 0;
      void'($urandom(32'd2024));
      d_valid  = 1'b0;
      d        = '0;
      q_bp     = 1'b1;
      resetn   = 1'b0;

      apply_reset(1'b0, 8'h00);
      check("rst_count", 32'(count), 32'h0);
      check("rst_q_valid", 32'(q_valid), 32'h0);
      check("rst_d_bp", 32'(d_bp), 32'h0);

      // Fill with downstream stalled.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'(8'h11 * (i + 1)), 1'b1, acc, cons);
         check("fill_count", 32'(count), 32'(i + 1));
      end
      check("fill_d_bp", 32'(d_bp), 32'h1);
      step(1'b1, 8'h55, 1'b1, acc, cons);
      check("fill_reject", 32'(count), 32'h4);

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         #1 check("drain_q", 32'(q), 32'(8'h11 * (i + 1)));
         step(1'b0, 8'h00, 1'b0, acc, cons);
      end
      check("drain_q_valid", 32'(q_valid), 32'h0);
      check("drain_count", 32'(count), 32'h0);

      // Streaming at one token per cycle.
      step(1'b1, 8'h00, 1'b0, acc, cons);
      check("stream_first", 32'(q_valid), 32'h1);
      for (int i = 1; i < 16; i++) begin
         #1;
         check("stream_q", 32'(q), 32'(i - 1));
         check("stream_count", 32'(count), 32'h1);
         step(1'b1, 8'(i), 1'b0, acc, cons);
      end
      check("stream_last", 32'(q), 32'h0F);
      step(1'b0, 8'h00, 1'b0, acc, cons);
      check("stream_empty", 32'(q_valid), 32'h0);

      // Full with a simultaneous pop: the freed slot is only usable next cycle.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 * (i + 1)), 1'b1, acc, cons);
      check("fp_full", 32'(d_bp), 32'h1);
      step(1'b1, 8'h99, 1'b0, acc, cons);
      check("fp_count3", 32'(count), 32'h3);
      check("fp_head", 32'(q), 32'h22);
      step(1'b1, 8'h99, 1'b1, acc, cons);
      check("fp_count4", 32'(count), 32'h4);
      while (model.size() != 0) step(1'b0, 8'h00, 1'b0, acc, cons);

      // Wrap with random downstream stalls.
      pushed = 0;
      popped = 0;
      cyc    = 0;
      while ((pushed < 10 || model.size() != 0) && cyc < 200) begin
         q_seen = q;
         step(pushed < 10, 8'(8'hA0 + pushed), 1'($urandom_range(0, 1)), acc, cons);
         if (cons) begin
            check("wrap_order", 32'(q_seen), 32'(8'hA0 + popped));
            popped++;
         end
         if (acc) pushed++;
         cyc++;
      end
      check("wrap_popped", 32'(popped), 32'd10);

      // Reset mid-operation discards stored tokens.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, acc, cons);
      check("mid_count", 32'(count), 32'h3);
      apply_reset(1'b1, 8'h77);
      check("mid_rst_count", 32'(count), 32'h0);
      check("mid_rst_q_valid", 32'(q_valid), 32'h0);
      check("mid_rst_d_bp", 32'(d_bp), 32'h0);
      step(1'b1, 8'h5A, 1'b1, acc, cons);
      check("mid_first_q", 32'(q), 32'h5A);
      check("mid_first_count", 32'(count), 32'h1);
      step(1'b0, 8'h00, 1'b0, acc, cons);
      check("mid_final_empty", 32'(q_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
